// File: rtl/genius_sequencer.sv
// Round-sequencing controller for a Simon-style memory game: plays an LFSR-derived
// colour sequence on four LEDs, checks button presses against it, and ends in WIN or LOSE.
module genius_sequencer #(
  parameter int SHOW_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int MAX_ROUND      = 8,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        R_n,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic [3:0]  btn,
  output logic [3:0]  led,
  output logic [3:0]  round,
  output logic        busy,
  output logic        win,
  output logic        lose
);

  localparam int MAX_A = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int TW    = $clog2(MAX_P + 1);

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ZERO  = {TW{1'b0}};
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [3:0]    ROUND_MAX = 4'(MAX_ROUND);
  localparam logic [15:0]   SEED_DFLT = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW_ON  = 3'd1,
    S_SHOW_OFF = 3'd2,
    S_WAIT_IN  = 3'd3,
    S_WIN      = 3'd4,
    S_LOSE     = 3'd5
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] c);
    case (c)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      2'd3:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  state_t        state_r, state_s;
  logic [3:0]    step_r, step_s;
  logic [TW-1:0] tmr_r, tmr_s;
  logic [3:0]    round_r, round_s;
  logic [15:0]   lfsr_r, lfsr_s;
  logic [15:0]   seed_r, seed_s;
  logic [3:0]    led_r, led_s;
  logic          busy_r, busy_s;
  logic          win_r, win_s;
  logic          lose_r, lose_s;

  // Next-state logic for the game controller, counters, LFSR and seed register
  always_comb begin
    state_s = state_r;
    step_s  = step_r;
    tmr_s   = tmr_r;
    round_s = round_r;
    lfsr_s  = lfsr_r;
    seed_s  = seed_r;
    case (state_r)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          seed_s  = (seed == 16'h0000) ? SEED_DFLT : seed;
          lfsr_s  = seed_s;
          round_s = 4'd1;
          step_s  = 4'd0;
          tmr_s   = TMR_ZERO;
          state_s = S_SHOW_ON;
        end else begin
          state_s = state_r;
        end
      end
      S_SHOW_ON: begin
        if (tmr_r == SHOW_LAST) begin
          tmr_s   = TMR_ZERO;
          state_s = S_SHOW_OFF;
        end else begin
          tmr_s = tmr_r + TMR_ONE;
        end
      end
      S_SHOW_OFF: begin
        if (tmr_r == GAP_LAST) begin
          tmr_s = TMR_ZERO;
          if (step_r + 4'd1 == round_r) begin
            step_s  = 4'd0;
            lfsr_s  = seed_r;
            state_s = S_WAIT_IN;
          end else begin
            step_s  = step_r + 4'd1;
            lfsr_s  = lfsr_next(lfsr_r);
            state_s = S_SHOW_ON;
          end
        end else begin
          tmr_s = tmr_r + TMR_ONE;
        end
      end
      S_WAIT_IN: begin
        // A press always takes priority over the timeout expiring on the same edge
        if (btn == 4'b0000) begin
          if (tmr_r == TMO_LAST) begin
            state_s = S_LOSE;
          end else begin
            tmr_s = tmr_r + TMR_ONE;
          end
        end else if (btn == onehot(lfsr_r[1:0])) begin
          tmr_s  = TMR_ZERO;
          lfsr_s = lfsr_next(lfsr_r);
          step_s = step_r + 4'd1;
          if (step_r + 4'd1 == round_r) begin
            if (round_r == ROUND_MAX) begin
              state_s = S_WIN;
            end else begin
              round_s = round_r + 4'd1;
              step_s  = 4'd0;
              lfsr_s  = seed_r;
              state_s = S_SHOW_ON;
            end
          end else begin
            state_s = S_WAIT_IN;
          end
        end else begin
          state_s = S_LOSE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track it without lag
  always_comb begin
    led_s  = 4'b0000;
    busy_s = 1'b0;
    win_s  = 1'b0;
    lose_s = 1'b0;
    case (state_s)
      S_SHOW_ON: begin
        led_s  = onehot(lfsr_s[1:0]);
        busy_s = 1'b1;
      end
      S_SHOW_OFF, S_WAIT_IN: busy_s = 1'b1;
      S_WIN:                 win_s  = 1'b1;
      S_LOSE:                lose_s = 1'b1;
      S_IDLE:                busy_s = 1'b0;
      default:               busy_s = 1'b0;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      state_r <= S_IDLE;
      step_r  <= 4'd0;
      tmr_r   <= TMR_ZERO;
      round_r <= 4'd0;
      lfsr_r  <= SEED_DFLT;
      seed_r  <= SEED_DFLT;
      led_r   <= 4'b0000;
      busy_r  <= 1'b0;
      win_r   <= 1'b0;
      lose_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
      tmr_r   <= tmr_s;
      round_r <= round_s;
      lfsr_r  <= lfsr_s;
      seed_r  <= seed_s;
      led_r   <= led_s;
      busy_r  <= busy_s;
      win_r   <= win_s;
      lose_r  <= lose_s;
    end
  end

  assign led   = led_r;
  assign round = round_r;
  assign busy  = busy_r;
  assign win   = win_r;
  assign lose  = lose_r;

endmodule
